// File: rtl/shift_reg_input.sv
// 74HC165 chain reader: a level change on i_start_toggle runs one load/shift scan.
// Optional SHIFT_REG_INPUT_CONTINUOUS_EN: free-running back-to-back scans from reset.
module shift_reg_input #(
   parameter int DATA_WIDTH = 3,
   parameter int DATA_SIZE  = 1 << DATA_WIDTH,
   parameter int CLK_DIV    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start_toggle,
   input  logic                 i_q7,
   output logic                 o_pl_n,
   output logic                 o_cp,
   output logic [DATA_SIZE-1:0] o_value,
   output logic                 o_valid,
   output logic                 o_busy
);

   localparam int PW = $clog2(CLK_DIV) + 1;
   localparam int CW = DATA_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_SAMPLE,
      S_HIGH,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [PW-1:0]        r_phase;
   logic [CW-1:0]        r_cnt;
   logic [DATA_SIZE-1:0] r_shift;
   logic                 r_last_toggle;

   logic                 w_phase_end;
   logic                 w_last_bit;
   logic [DATA_SIZE-1:0] w_shift_next;

   assign w_phase_end  = (r_phase == PW'(CLK_DIV - 1));
   assign w_last_bit   = (r_cnt == CW'(DATA_SIZE - 1));
   assign w_shift_next = {r_shift[DATA_SIZE-2:0], i_q7};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_phase       <= '0;
         r_cnt         <= '0;
         r_shift       <= '0;
         r_last_toggle <= i_start_toggle;
         o_pl_n        <= 1'b1;
         o_cp          <= 1'b0;
         o_value       <= '0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_last_toggle <= i_start_toggle;
`ifdef SHIFT_REG_INPUT_CONTINUOUS_EN
               if (1'b1) begin
`else
               if (i_start_toggle != r_last_toggle) begin
`endif
                  r_shift <= '0;
                  r_cnt   <= '0;
                  r_phase <= '0;
                  r_state <= S_LOAD;
                  o_pl_n  <= 1'b0;
                  o_cp    <= 1'b0;
                  o_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  r_state <= S_SETTLE;
                  o_pl_n  <= 1'b1;
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_SETTLE: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  r_state <= S_SAMPLE;
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_SAMPLE: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  r_shift <= w_shift_next;
                  r_cnt   <= r_cnt + CW'(1);
                  if (w_last_bit) begin
                     r_state <= S_DONE;
                     o_value <= w_shift_next;
                     o_valid <= 1'b1;
                  end else begin
                     r_state <= S_HIGH;
                     o_cp    <= 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_HIGH: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  r_state <= S_SAMPLE;
                  o_cp    <= 1'b0;
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
`ifdef SHIFT_REG_INPUT_CONTINUOUS_EN
               // One rest cycle in IDLE with busy held keeps the 2 + CLK_DIV*(2N+1) scan period.
               o_busy  <= 1'b1;
`else
               o_busy  <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
               o_pl_n  <= 1'b1;
               o_cp    <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_reg_input.sv
// Scoreboard bench: two DUTs (8 bits / CLK_DIV=1 and 16 bits / CLK_DIV=3) each read a '165 chain model.
module tb_shift_reg_input;

   localparam int NA    = 8;
   localparam int DA    = 1;
   localparam int NB    = 16;
   localparam int DB    = 3;
   localparam int LAT_A = 1 + DA * (2 * NA + 1);
   localparam int LAT_B = 1 + DB * (2 * NB + 1);

   typedef struct {
      logic [NB-1:0] val;
      int            exp_cyc;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tog_a = 1'b0, tog_b = 1'b0;
   logic [NA-1:0] par_a = '0;
   logic [NB-1:0] par_b = '0;
   logic          q7_a, q7_b;
   logic          pl_a, cp_a, valid_a, busy_a;
   logic          pl_b, cp_b, valid_b, busy_b;
   logic [NA-1:0] value_a;
   logic [NB-1:0] value_b;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   sb_t qa[$];
   sb_t qb[$];

   shift_reg_input #(.DATA_WIDTH(3), .CLK_DIV(DA)) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_start_toggle(tog_a), .i_q7(q7_a),
      .o_pl_n(pl_a), .o_cp(cp_a), .o_value(value_a), .o_valid(valid_a), .o_busy(busy_a)
   );

   shift_reg_input #(.DATA_WIDTH(4), .CLK_DIV(DB)) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_start_toggle(tog_b), .i_q7(q7_b),
      .o_pl_n(pl_b), .o_cp(cp_b), .o_value(value_b), .o_valid(valid_b), .o_busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // '165 chain models: load while PL low, shift on a CP rising edge.
   logic [NA-1:0] sr_a = '0;
   logic [NB-1:0] sr_b = '0;
   logic          cpd_a = 1'b0, cpd_b = 1'b0;
   always @(posedge clk) begin
      cpd_a <= cp_a;
      cpd_b <= cp_b;
      if (!pl_a) sr_a <= par_a;
      else if (cp_a && !cpd_a) sr_a <= sr_a << 1;
      if (!pl_b) sr_b <= par_b;
      else if (cp_b && !cpd_b) sr_b <= sr_b << 1;
   end
   assign q7_a = sr_a[NA-1];
   assign q7_b = sr_b[NB-1];

   int            pl_lo_a = 0, rise_a = 0, last_valid_a = 0;
   logic          prev_a = 1'b0;
   logic [NA-1:0] hold_a = '0;
   sb_t           ea;
   always @(negedge clk) begin
      if (rst) begin
         pl_lo_a = 0; rise_a = 0; prev_a = 1'b0; hold_a = '0;
      end else begin
         if (!pl_a) pl_lo_a++;
         if (cp_a && !prev_a) rise_a++;
         prev_a = cp_a;
         if (valid_a) begin
            if (qa.size() == 0) begin
               check("a_spurious_valid", 32'd1, 32'd0);
            end else begin
               ea = qa.pop_front();
               check("a_value", 32'(value_a), 32'(ea.val[NA-1:0]));
               check("a_latency", cyc, (ea.exp_cyc < 0) ? last_valid_a + 1 + LAT_A : ea.exp_cyc);
               check("a_pl_cycles", pl_lo_a, DA);
               check("a_cp_rises", rise_a, NA - 1);
               hold_a = ea.val[NA-1:0];
            end
            last_valid_a = cyc; pl_lo_a = 0; rise_a = 0;
         end else begin
            check("a_value_hold", 32'(value_a), 32'(hold_a));
         end
      end
   end

   int            pl_lo_b = 0, rise_b = 0, hi_b = 0, lo_b = 0;
   logic          prev_b = 1'b0;
   logic [NB-1:0] hold_b = '0;
   sb_t           eb;
   always @(negedge clk) begin
      if (rst) begin
         pl_lo_b = 0; rise_b = 0; hi_b = 0; lo_b = 0; prev_b = 1'b0; hold_b = '0;
      end else begin
         if (!pl_b) pl_lo_b++;
         if (cp_b && !prev_b) begin
            if (rise_b > 0) check("b_cp_low_len", lo_b, DB);
            rise_b++; hi_b = 1;
         end else if (cp_b) begin
            hi_b++;
         end else if (prev_b) begin
            check("b_cp_high_len", hi_b, DB); lo_b = 1;
         end else begin
            lo_b++;
         end
         prev_b = cp_b;
         if (valid_b) begin
            if (qb.size() == 0) begin
               check("b_spurious_valid", 32'd1, 32'd0);
            end else begin
               eb = qb.pop_front();
               check("b_value", 32'(value_b), 32'(eb.val));
               check("b_latency", cyc, eb.exp_cyc);
               check("b_pl_cycles", pl_lo_b, DB);
               check("b_cp_rises", rise_b, NB - 1);
               hold_b = eb.val;
            end
            pl_lo_b = 0; rise_b = 0;
         end else begin
            check("b_value_hold", 32'(value_b), 32'(hold_b));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_a(input logic [NA-1:0] v, input int settle);
      par_a = v;
      qa.push_back('{val: NB'(v), exp_cyc: cyc + LAT_A});
      tog_a = ~tog_a;
      step(settle);
      check("a_scan_done", qa.size(), 0);
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      check("rst_pl_a", 32'(pl_a), 32'd1);
      check("rst_cp_a", 32'(cp_a), 32'd0);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_value_b", 32'(value_b), 32'd0);
      step(5);

      scan_a(8'hA5, LAT_A + 5);

      par_b = 16'h1234;
      qb.push_back('{val: 16'h1234, exp_cyc: cyc + LAT_B});
      tog_b = ~tog_b;
      step(LAT_B + 8);
      check("b_scan_done", qb.size(), 0);

      scan_a(8'hFF, LAT_A + 3);
      scan_a(8'h00, LAT_A + 3);

      // Two flips mid-scan: net change zero, no extra scan.
      par_a = 8'h3C;
      qa.push_back('{val: NB'(8'h3C), exp_cyc: cyc + LAT_A});
      tog_a = ~tog_a;
      step(3); tog_a = ~tog_a;
      step(3); tog_a = ~tog_a;
      step(3 * LAT_A);
      check("a_two_flip_done", qa.size(), 0);

      // One flip mid-scan: exactly one more scan right after DONE.
      par_a = 8'h5A;
      qa.push_back('{val: NB'(8'h5A), exp_cyc: cyc + LAT_A});
      tog_a = ~tog_a;
      step(4);
      qa.push_back('{val: NB'(8'h5A), exp_cyc: -1});
      tog_a = ~tog_a;
      step(3 * LAT_A);
      check("a_one_flip_done", qa.size(), 0);

      // Reset during the 4th SAMPLE phase.
      par_a = 8'h96;
      qa.push_back('{val: NB'(8'h96), exp_cyc: cyc + LAT_A});
      tog_a = ~tog_a;
      step(9);
      check("mid_busy_a", 32'(busy_a), 32'd1);
      check("mid_cp_a", 32'(cp_a), 32'd0);
      rst = 1'b1;
      qa.delete();
      step(1);
      check("abort_pl_a", 32'(pl_a), 32'd1);
      check("abort_cp_a", 32'(cp_a), 32'd0);
      check("abort_busy_a", 32'(busy_a), 32'd0);
      check("abort_value_a", 32'(value_a), 32'd0);
      check("abort_valid_a", 32'(valid_a), 32'd0);
      rst = 1'b0;
      step(2 * LAT_A);
      scan_a(8'hC3, LAT_A + 3);

      check("final_qa_empty", qa.size(), 0);
      check("final_qb_empty", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
